mac_row_sched: RTL and testbench
================================

Name: mac_row_sched

Overview:
- Upstream/downstream sequencer wrapped around one mac4x4 instance.
- Accepts a job of N rows, each row being one A row plus its C row, on a valid/ready stream.
- Drives mac4x4 en/a/bidx/c at one row per cycle, captures r/r_v into a small result FIFO, and presents results on a valid/ready output stream with a last flag.
- mac4x4 has no stall, so issue is credit-gated: a result always has a FIFO slot when it arrives.

Parameters:
- DEPTH, 4: result FIFO entries; power of two, at least 2.
- DW, 16: element width of A, C and R lanes.
- RW, 8: width of the row-count field.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- num_rows  in  RW  rows in the job; latched on start
- bidx  in  5  weight index for the job; latched on start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job end
- in_v  in  1  row valid
- in_rdy  out  1  row ready
- in_a  in  4xDW  A row
- in_c  in  4xDW  C row
- mac_en  out  1  to mac4x4 en
- mac_a  out  4xDW  to mac4x4 a
- mac_bidx  out  5  to mac4x4 bidx
- mac_c  out  4xDW  to mac4x4 c
- mac_r_v  in  1  from mac4x4 r_v
- mac_r  in  4xDW  from mac4x4 r
- out_v  out  1  result valid
- out_rdy  in  1  result ready
- out_r  out  4xDW  result row
- out_last  out  1  marks the final row of the job

Behaviour:
- Reset (async, active-low) clears: state to IDLE, row counters, inflight, FIFO pointers and count.
  - Outputs during and after reset: busy=0, done=0, in_rdy=0, mac_en=0, out_v=0, out_last=0.
  - mac_bidx is a latched register, reset to 0.
  - A reset mid-job discards all rows and FIFO contents; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, start with num_rows!=0: latch num_rows and bidx, clear issue and result counters, go to RUN.
  - IDLE, start with num_rows==0: go to DONE directly; no rows are accepted.
  - RUN: issue rows (see Issue); when the final row handshakes, go to DRAIN.
  - DRAIN: in_rdy=0; when the result counter has reached num_rows and the FIFO is empty, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start in any state other than IDLE is ignored.
- Issue, RUN only:
  - in_rdy = (fifo_count + inflight) < DEPTH.
  - inflight is a 1-bit register equal to mac_en delayed by one cycle.
  - A pop in the same cycle is not counted toward credit (conservative).
  - mac_en = in_v & in_rdy, combinational.
  - mac_a = in_a and mac_c = in_c, pass-through. mac_bidx is the latched bidx.
  - Issue counter increments on each handshake.
- Latency: the result arrives on mac_r_v exactly 1 cycle after mac_en. It appears on out_v at the earliest 1 cycle after that (FIFO registered write, show-ahead read).
- FIFO:
  - Push on mac_r_v; pop on out_v & out_rdy.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Pushing while full is impossible by construction; the bench asserts against it. If it occurs, the push is dropped.
  - out_v = count != 0. out_r = head entry.
  - out_last is stored per entry, set when the result counter equals num_rows-1 at push time.
- Result counter increments on each push.
- mac_r_v outside RUN/DRAIN (a spurious result) is ignored and not pushed.
- Ordering: results leave in row-issue order, with no reordering or merging.
- Arithmetic is owned by mac4x4; this block never modifies data.

Decomposition:
- Shared package: state enum (IDLE, RUN, DRAIN, DONE) and a row typedef (4 x DW logic) shared with mac4x4 users.
- One sub-module: sync_fifo (params DEPTH and width; push, pop, full, empty, count, head). Instantiated with width 4*DW+1 to carry the last flag.
- Remaining logic (FSM, counters, credit) stays in mac_row_sched.

Test Plan:
- Basic job: start, num_rows=3, bidx=5; stream 3 rows with out_rdy=1. Expect:
  - mac_en for 3 consecutive cycles and mac_bidx=5;
  - out_v rows in order with out_last only on the 3rd;
  - done pulses once, busy drops after done.
- Backpressure: num_rows=10, out_rdy=0. Expect:
  - in_rdy falls after exactly 4 rows issued (DEPTH=4) and FIFO holds 4;
  - raising out_rdy drains all 10 rows in order, none lost, none duplicated.
- Zero rows: start with num_rows=0. Expect busy for 1 cycle (DONE), done pulse, in_rdy stays 0, out_v stays 0.
- Bubbles: in_v toggling 1,0,1,0 with out_rdy random over num_rows=8. Expect 8 ordered results, out_last on the 8th, never a push while full.
- Start while busy: pulse start with num_rows=2 mid-job. Expect it ignored; the original job count and bidx are unchanged.
- Reset mid-job: assert reset_n low after 2 of 5 rows. Expect all outputs at reset values, FIFO empty, no done pulse; a new job of 1 row then completes normally.

Source files
------------

// File: rtl/mac_row_sched_pkg.sv
// Shared types for the mac4x4 row sequencer: FSM state and the 4-lane row.
package mac_row_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ROW_DW = 16;

    typedef logic [3:0][ROW_DW-1:0] row_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: registered write, show-ahead read; a push while full is dropped.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mac_row_sched.sv
// Row sequencer around mac4x4: credit-gated issue, result FIFO, job FSM.
module mac_row_sched
    import mac_row_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int RW    = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [RW-1:0]        num_rows,
    input  logic [4:0]           bidx,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_v,
    output logic                 in_rdy,
    input  logic [3:0][DW-1:0]   in_a,
    input  logic [3:0][DW-1:0]   in_c,
    output logic                 mac_en,
    output logic [3:0][DW-1:0]   mac_a,
    output logic [4:0]           mac_bidx,
    output logic [3:0][DW-1:0]   mac_c,
    input  logic                 mac_r_v,
    input  logic [3:0][DW-1:0]   mac_r,
    output logic                 out_v,
    input  logic                 out_rdy,
    output logic [3:0][DW-1:0]   out_r,
    output logic                 out_last
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = 4 * DW + 1;

    state_t        state_q, state_d;
    logic [RW-1:0] num_rows_q, num_rows_d;
    logic [4:0]    bidx_q, bidx_d;
    logic [RW-1:0] issue_cnt_q, issue_cnt_d;
    logic [RW-1:0] res_cnt_q, res_cnt_d;
    logic          inflight_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [FW-1:0] fifo_head;
    logic          push, fifo_push, pop, push_last;

    // Credit covers rows already in the FIFO plus the one inside mac4x4;
    // a same-cycle pop is deliberately not credited back.
    assign in_rdy   = (state_q == RUN) && ((fifo_count + CW'(inflight_q)) < CW'(DEPTH));
    assign mac_en   = in_v && in_rdy;
    assign mac_a    = in_a;
    assign mac_c    = in_c;
    assign mac_bidx = bidx_q;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    assign push      = mac_r_v && ((state_q == RUN) || (state_q == DRAIN));
    assign fifo_push = push && !fifo_full;
    assign push_last = (res_cnt_q == num_rows_q - RW'(1));
    assign pop       = out_v && out_rdy;

    assign out_v    = !fifo_empty;
    assign out_r    = fifo_head[4*DW-1:0];
    assign out_last = fifo_head[4*DW] && out_v;

    sync_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     ({push_last, mac_r}),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        bidx_d      = bidx_q;
        issue_cnt_d = issue_cnt_q;
        res_cnt_d   = res_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        num_rows_d  = num_rows;
                        bidx_d      = bidx;
                        issue_cnt_d = '0;
                        res_cnt_d   = '0;
                        state_d     = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (mac_en) begin
                    issue_cnt_d = issue_cnt_q + RW'(1);
                    if (issue_cnt_q == num_rows_q - RW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((res_cnt_q == num_rows_q) && fifo_empty) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (push) res_cnt_d = res_cnt_q + RW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            num_rows_q  <= '0;
            bidx_q      <= '0;
            issue_cnt_q <= '0;
            res_cnt_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            bidx_q      <= bidx_d;
            issue_cnt_q <= issue_cnt_d;
            res_cnt_q   <= res_cnt_d;
            inflight_q  <= mac_en;
        end
    end

endmodule

// File: tb/tb_mac_row_sched.sv
// Bench for mac_row_sched: behavioural mac4x4 stand-in, job table plus corner sequences, scoreboard.
module tb_mac_row_sched;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int RW    = 8;

    logic                clock, reset_n, start;
    logic [RW-1:0]       num_rows;
    logic [4:0]          bidx;
    logic                busy, done, in_v, in_rdy, mac_en, mac_r_v, out_v, out_rdy, out_last;
    logic [3:0][DW-1:0]  in_a, in_c, mac_a, mac_c, mac_r, out_r;
    logic [4:0]          mac_bidx;

    mac_row_sched #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .num_rows(num_rows), .bidx(bidx),
        .busy(busy), .done(done), .in_v(in_v), .in_rdy(in_rdy), .in_a(in_a), .in_c(in_c),
        .mac_en(mac_en), .mac_a(mac_a), .mac_bidx(mac_bidx), .mac_c(mac_c),
        .mac_r_v(mac_r_v), .mac_r(mac_r), .out_v(out_v), .out_rdy(out_rdy),
        .out_r(out_r), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [63:0] r; logic last; } exp_t;
    typedef struct { int nrows; int b; bit bubble; int rdy_pct; int exp_done; } job_t;

    exp_t        sbq[$];
    exp_t        e;
    int          n_cmp = 0, n_bad = 0;
    int          job_n, issued, done_cnt, n_out;
    logic [4:0]  job_bidx;
    int          rdy_pct = 100;
    logic        spur = 1'b0;
    int          f_cyc, l_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] fexp(input logic [63:0] a, input logic [63:0] c, input logic [4:0] b);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = a[i*16 +: 16] + c[i*16 +: 16] + 16'(b);
        return r;
    endfunction

    // mac4x4 stand-in: one-cycle latency, lane = a + c + bidx
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mac_r_v <= 1'b0;
            mac_r   <= '0;
        end else begin
            mac_r_v <= mac_en | spur;
            for (int i = 0; i < 4; i++) mac_r[i] <= mac_a[i] + mac_c[i] + DW'(mac_bidx);
        end
    end

    always @(posedge clock) begin
        #2;
        out_rdy = ($urandom_range(99) < rdy_pct);
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (out_v && out_rdy) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_extra: got row %0h expected no row", out_r);
                end else begin
                    e = sbq.pop_front();
                    chk("out_r", out_r, e.r);
                    chk("out_last", 64'(out_last), 64'(e.last));
                end
                n_out++;
            end
            if (done) done_cnt++;
            if (mac_r_v && busy && dut.u_fifo.full) begin
                n_cmp++; n_bad++;
                $display("FAIL push_while_full: got push with fifo full expected none");
            end
        end
    end

    task automatic start_job(input int n, input int b);
        job_n = n; job_bidx = 5'(b); issued = 0; done_cnt = 0; n_out = 0;
        start = 1'b1; num_rows = RW'(n); bidx = 5'(b);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic drive_rows(input int target, input bit bubble, input int max_cyc);
        int cyc = 0;
        bit hold = 1'b0;
        while (issued < target && cyc < max_cyc) begin
            if (!hold) begin
                in_a = {$urandom(), $urandom()};
                in_c = {$urandom(), $urandom()};
            end
            in_v = 1'b1;
            @(negedge clock);
            if (mac_en) begin
                chk("mac_bidx", 64'(mac_bidx), 64'(job_bidx));
                sbq.push_back('{fexp(in_a, in_c, job_bidx), (issued == job_n - 1)});
                if (issued == 0) f_cyc = cyc;
                l_cyc = cyc;
                issued++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
            end
            @(posedge clock); #1; cyc++;
            if (bubble && !hold) begin
                in_v = 1'b0;
                @(posedge clock); #1; cyc++;
            end
        end
        in_v = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int c = 0;
        do begin
            @(negedge clock); c++;
        end while (!done && c < max_cyc);
        chk("done_seen", 64'(done), 64'd1);
        @(negedge clock);
        chk("busy_after_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
    endtask

    task automatic run_job(input job_t j);
        rdy_pct = j.rdy_pct;
        start_job(j.nrows, j.b);
        drive_rows(j.nrows, j.bubble, 3000);
        chk("issued", 64'(issued), 64'(j.nrows));
        if (!j.bubble && j.rdy_pct == 100) chk("issue_span", 64'(l_cyc - f_cyc), 64'(j.nrows - 1));
        wait_done(3000);
        chk("results", 64'(n_out), 64'(j.nrows));
        chk("done_pulses", 64'(done_cnt), 64'(j.exp_done));
        chk("sb_empty", 64'(sbq.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_mac_en", 64'(mac_en), 64'd0);
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_mac_bidx", 64'(mac_bidx), 64'd0);
    endtask

    job_t jobs[4];

    initial begin
        jobs[0] = '{nrows: 3, b: 5,  bubble: 1'b0, rdy_pct: 100, exp_done: 1};
        jobs[1] = '{nrows: 8, b: 2,  bubble: 1'b1, rdy_pct: 50,  exp_done: 1};
        jobs[2] = '{nrows: 6, b: 31, bubble: 1'b0, rdy_pct: 100, exp_done: 1};
        jobs[3] = '{nrows: 5, b: 1,  bubble: 1'b1, rdy_pct: 30,  exp_done: 1};

        reset_n = 1'b0; start = 1'b0; num_rows = '0; bidx = '0;
        in_v = 1'b1; in_a = '0; in_c = '0; out_rdy = 1'b1;
        #2;
        chk_reset_outputs();
        repeat (3) @(posedge clock);
        #1;
        in_v = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int k = 0; k < 4; k++) run_job(jobs[k]);

        // backpressure: credit stops issue at DEPTH rows
        rdy_pct = 0;
        @(posedge clock); #1;
        start_job(10, 4);
        drive_rows(10, 1'b0, 8);
        chk("bp_issued", 64'(issued), 64'd4);
        @(negedge clock);
        chk("bp_in_rdy", 64'(in_rdy), 64'd0);
        chk("bp_fifo_count", 64'(dut.u_fifo.count), 64'd4);
        chk("bp_out_v", 64'(out_v), 64'd1);
        @(posedge clock); #1;
        rdy_pct = 100;
        drive_rows(10, 1'b0, 3000);
        wait_done(3000);
        chk("bp_results", 64'(n_out), 64'd10);
        chk("bp_done", 64'(done_cnt), 64'd1);
        chk("bp_sb_empty", 64'(sbq.size()), 64'd0);

        // zero rows: one DONE cycle, nothing accepted
        in_v = 1'b1;
        start_job(0, 3);
        @(negedge clock);
        chk("z_busy", 64'(busy), 64'd1);
        chk("z_done", 64'(done), 64'd1);
        chk("z_in_rdy", 64'(in_rdy), 64'd0);
        chk("z_mac_en", 64'(mac_en), 64'd0);
        @(negedge clock);
        chk("z_busy_end", 64'(busy), 64'd0);
        chk("z_done_end", 64'(done), 64'd0);
        chk("z_out_v", 64'(out_v), 64'd0);
        @(posedge clock); #1;
        in_v = 1'b0;
        chk("z_done_cnt", 64'(done_cnt), 64'd1);

        // spurious result while idle is ignored
        spur = 1'b1;
        @(posedge clock); #1;
        spur = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("spur_out_v", 64'(out_v), 64'd0);
        end
        @(posedge clock); #1;

        // start while busy is ignored
        rdy_pct = 100;
        start_job(4, 7);
        drive_rows(1, 1'b0, 50);
        start = 1'b1; num_rows = RW'(2); bidx = 5'd3;
        @(posedge clock); #1;
        start = 1'b0;
        drive_rows(4, 1'b0, 3000);
        wait_done(3000);
        chk("sb_results", 64'(n_out), 64'd4);
        chk("sb_done", 64'(done_cnt), 64'd1);

        // reset mid-job
        rdy_pct = 0;
        @(posedge clock); #1;
        start_job(5, 6);
        drive_rows(2, 1'b0, 50);
        in_v = 1'b1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clock);
        #1;
        sbq.delete();
        in_v = 1'b0;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("mr_out_v", 64'(out_v), 64'd0);
        end
        chk("mr_no_done", 64'(done_cnt), 64'd0);
        @(posedge clock); #1;
        run_job('{nrows: 1, b: 9, bubble: 1'b0, rdy_pct: 100, exp_done: 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
